pds_dut: RTL and testbench
==========================

# pds_dut

Store-and-forward packet data switch (PDS) with one byte-wide ingress stream and four egress ports. It buffers each ingress packet and checks its framing and trailing parity byte. A good packet is forwarded unchanged to the egress port named in its header byte; a bad packet is dropped and counted. It connects to the bench through the `pds_if` interface, and all ports below are members of that interface.

## Interface
- `NPORTS`, 4: number of egress ports; fixed at 4 because the header destination field is 2 bits.
- `MAX_LEN`, 64: maximum packet length in bytes, header and parity included.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: ingress byte valid.
- `in_sop` in 1: first byte of packet.
- `in_eop` in 1: last byte of packet, which is the parity byte.
- `in_data` in 8: ingress byte.
- `in_ready` out 1: switch can accept an ingress byte.
- `out_valid` out 4: one-hot; bit p means port p is presenting a byte.
- `out_sop` out 1: shared egress first-byte flag.
- `out_eop` out 1: shared egress last-byte flag.
- `out_data` out 8: shared egress byte.
- `out_ready` in 4: per-port sink ready.
- `pkt_ok_cnt` out 16: count of forwarded packets; saturates at 0xFFFF.
- `pkt_err_cnt` out 16: count of dropped packets; saturates at 0xFFFF.

## Operation

**Packet format**
- Byte 0 is the header. `hdr[1:0]` is the destination port; `hdr[7:2]` is reserved and forwarded unchanged.
- The last byte (the one carrying `in_eop`) is parity: the XOR of all preceding bytes of the packet.
- Legal length is 2..`MAX_LEN` bytes.

**Handshake**
- A byte transfers on a rising edge where `valid` and `ready` are both high. This holds on ingress (`in_valid`/`in_ready`) and on egress (`out_valid[p]`/`out_ready[p]`).

**State machine: IDLE, RECV, CHECK, SEND**
- **IDLE**
  - `in_ready`=1.
  - A transferred byte with `in_sop`=1 is stored at index 0, the running XOR is initialised, and the state goes to RECV.
  - A transferred byte with `in_sop`=1 and `in_eop`=1 is a 1-byte packet: error, stay in IDLE.
  - Bytes without `in_sop` are discarded silently (no count).
- **RECV**
  - `in_ready`=1.
  - Each transferred byte is stored and the running XOR is updated; non-eop bytes are XORed in.
  - On `in_eop`: compare the byte against the running XOR and go to CHECK.
  - If a byte would exceed `MAX_LEN`: error, go to IDLE, and discard the remaining bytes until the next sop.
  - `in_sop` arriving in RECV: count an error for the aborted packet and restart reception with that byte as a new header.
- **CHECK**
  - One cycle, `in_ready`=0.
  - Parity good: increment `pkt_ok_cnt`, go to SEND.
  - Parity bad: increment `pkt_err_cnt`, go to IDLE.
  - `pkt_ok_cnt` counts at CHECK, not at send completion.
- **SEND**
  - `in_ready`=0.
  - Drive `out_valid[hdr[1:0]]`=1 with stored byte i; `out_sop`=1 when i=0, `out_eop`=1 when i=len-1.
  - Advance i on each handshake.
  - After the eop byte transfers, go to IDLE.
  - Other `out_valid` bits stay 0. `out_ready` of non-selected ports is ignored.
- Error counting rule: every error case above increments `pkt_err_cnt` by exactly 1.

## Timing
- Reset (synchronous, `rst`=1 at a rising edge) has priority over everything, including mid-RECV and mid-SEND.
  - Reset values: state=IDLE; `in_ready`, `out_valid`, `out_sop`, `out_eop`, `out_data`, and both counters are 0.
  - `in_ready` is 0 while `rst`=1 and rises to 1 in the first cycle after `rst` deasserts.
  - A packet in flight is lost and not counted.
- Latency: if the eop byte transfers at edge k, the state is CHECK during cycle k..k+1. `out_valid` and the header byte are presented from edge k+1 (first possible transfer at edge k+2).
- Back-to-back bytes every cycle are accepted on ingress. Egress throughput is one byte per cycle while `out_ready` is held high.
- `out_valid`/`out_data`/`out_sop`/`out_eop` are held stable while `out_ready`=0.
- `in_ready` drops combinationally-free: it is registered and derived from state, so it is 0 in the cycle after eop transfer.
- Egress outputs are all 0 outside SEND.

## Test plan
- Reset, then the packet {0x01, 0xAA, 0x55, 0x01^0xAA^0x55=0xFE} with `out_ready`=4'hF. Required:
  - `out_valid`=4'b0010 on port 1, with bytes 01 AA 55 FE, sop on 01, eop on FE.
  - `pkt_ok_cnt`=1, `pkt_err_cnt`=0.
  - `in_ready` back to 1 after the FE transfer.
- The same packet with a parity byte of 0x00. Required: no `out_valid`, `pkt_err_cnt`=1, `in_ready` is 0 for exactly one cycle after eop.
- Five packets to ports 0, 1, 2, 3, 1, each followed by its correct parity, with random `out_ready` stalls on the destination port. Required: each packet appears intact only on its port, data is held stable during stalls, and `pkt_ok_cnt`=5.
- Error framing cases: a 1-byte packet (sop+eop on 0x02), a 65-byte packet, and a sop in mid-packet followed by a valid 3-byte packet {0x03, 0x10, 0x13}. Required: `pkt_err_cnt`=3, and the valid packet is forwarded on port 3.
- Assert `rst` for one cycle mid-SEND of a 10-byte packet. Required: all outputs go to 0 on the next edge, counters are 0, and the next correct packet is forwarded normally.
- Counter saturation: preload by sending 65,536 good packets (or force). Required: `pkt_ok_cnt` holds at 0xFFFF.

Source files
------------

// File: rtl/pds_if.sv
// rtl/pds_if.sv - signal bundle between the packet data switch and its environment
//
// Purpose: groups every pds_dut port except the clock, which comes in as the
// interface port.
// Ports:
//   clk        in  switch clock
//   rst        synchronous active-high reset
//   in_*       byte-wide ingress stream (valid/sop/eop/data, ready back)
//   out_*      shared egress byte with one-hot per-port valid and per-port ready
//   pkt_*_cnt  saturating forwarded / dropped packet counters
interface pds_if #(
  parameter int NPORTS = 4
) (
  input logic clk
);
  logic              rst;
  logic              in_valid;
  logic              in_sop;
  logic              in_eop;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [NPORTS-1:0] out_valid;
  logic              out_sop;
  logic              out_eop;
  logic [7:0]        out_data;
  logic [NPORTS-1:0] out_ready;
  logic [15:0]       pkt_ok_cnt;
  logic [15:0]       pkt_err_cnt;
endinterface

// File: rtl/pds_dut.sv
// rtl/pds_dut.sv - store-and-forward packet switch, one ingress stream, four egress ports
//
// Purpose: buffers a whole packet, checks framing and its trailing XOR parity
// byte, then replays a good packet on the port named by hdr[1:0]. Bad packets
// are dropped and counted.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_sop/in_eop/in_data  ingress byte stream
//   in_ready                      registered ingress ready (high in IDLE/RECV)
//   out_valid[NPORTS]             one-hot egress valid, bit = destination port
//   out_sop/out_eop/out_data      shared egress byte and framing flags
//   out_ready[NPORTS]             per-port sink ready
//   pkt_ok_cnt/pkt_err_cnt        saturating forwarded / dropped counters
module pds_dut #(
  parameter int NPORTS  = 4,
  parameter int MAX_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [NPORTS-1:0] out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [7:0]        out_data,
  input  logic [NPORTS-1:0] out_ready,
  output logic [15:0]       pkt_ok_cnt,
  output logic [15:0]       pkt_err_cnt
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int CW = IW + 1;
  // Write index equal to this means the buffer is already full.
  localparam logic [CW-1:0] LEN_FULL = CW'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RECV, CHECK, SEND} state_t;

  state_t        state, next_state;
  logic [7:0]    mem [MAX_LEN];
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] rd_idx;
  logic [CW-1:0] last_idx;
  logic [7:0]    xor_acc;
  logic [1:0]    dest;
  logic          par_ok;
  logic [15:0]   ok_cnt_q;
  logic [15:0]   err_cnt_q;
  logic          in_xfer;
  logic          out_xfer;
  logic          ok_inc;
  logic          err_inc;
  logic          rx_state;

  assign rx_state    = (state == IDLE) || (state == RECV);
  assign in_xfer     = in_valid && in_ready && rx_state;
  assign out_xfer    = (state == SEND) && out_ready[dest];
  assign pkt_ok_cnt  = ok_cnt_q;
  assign pkt_err_cnt = err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ok_inc     = 1'b0;
    err_inc    = 1'b0;
    out_valid  = '0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    out_data   = '0;
    case (state)
      IDLE: begin
        // Non-sop bytes here are stray tails of a dropped packet: ignore them.
        if (in_xfer && in_sop) begin
          if (in_eop) err_inc = 1'b1;
          else        next_state = RECV;
        end
      end
      RECV: begin
        if (in_xfer) begin
          if (in_sop) begin
            // Aborted packet; the sop byte restarts reception.
            err_inc = 1'b1;
            if (in_eop) next_state = IDLE;
          end else if (wr_idx == LEN_FULL) begin
            err_inc    = 1'b1;
            next_state = IDLE;
          end else if (in_eop) begin
            next_state = CHECK;
          end
        end
      end
      CHECK: begin
        if (par_ok) begin
          ok_inc     = 1'b1;
          next_state = SEND;
        end else begin
          err_inc    = 1'b1;
          next_state = IDLE;
        end
      end
      SEND: begin
        out_valid[dest] = 1'b1;
        out_sop         = (rd_idx == '0);
        out_eop         = (rd_idx == last_idx);
        out_data        = mem[rd_idx[IW-1:0]];
        if (out_xfer && (rd_idx == last_idx)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      last_idx <= '0;
      xor_acc  <= '0;
      dest     <= '0;
      par_ok   <= 1'b0;
    end else begin
      in_ready <= (next_state == IDLE) || (next_state == RECV);
      if (in_xfer && in_sop) begin
        wr_idx  <= 1'b1;
        xor_acc <= in_data;
        dest    <= in_data[1:0];
      end else if (in_xfer && (state == RECV) && (wr_idx != LEN_FULL)) begin
        if (in_eop) begin
          par_ok   <= (in_data == xor_acc);
          last_idx <= wr_idx;
        end else begin
          xor_acc <= xor_acc ^ in_data;
          wr_idx  <= wr_idx + 1'b1;
        end
      end
      if (state == CHECK)  rd_idx <= '0;
      else if (out_xfer)   rd_idx <= rd_idx + 1'b1;
    end
  end

  // Packet buffer: no reset, contents are only read after being written.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      if (in_sop)
        mem[0] <= in_data;
      else if ((state == RECV) && (wr_idx != LEN_FULL))
        mem[wr_idx[IW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (ok_inc && (ok_cnt_q != 16'hFFFF))   ok_cnt_q  <= ok_cnt_q + 1'b1;
      if (err_inc && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pds_dut.sv
// tb/tb_pds_dut.sv - directed self-checking bench for pds_dut
module tb_pds_dut;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  pds_if #(.NPORTS(4)) bus (.clk(clk));

  pds_dut #(.NPORTS(4), .MAX_LEN(64)) dut (
    .clk        (clk),
    .rst        (bus.rst),
    .in_valid   (bus.in_valid),
    .in_sop     (bus.in_sop),
    .in_eop     (bus.in_eop),
    .in_data    (bus.in_data),
    .in_ready   (bus.in_ready),
    .out_valid  (bus.out_valid),
    .out_sop    (bus.out_sop),
    .out_eop    (bus.out_eop),
    .out_data   (bus.out_data),
    .out_ready  (bus.out_ready),
    .pkt_ok_cnt (bus.pkt_ok_cnt),
    .pkt_err_cnt(bus.pkt_err_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] pkt[$];
  logic [7:0] rx_d[$];
  int         rx_p[$];
  logic       rx_s[$];
  logic       rx_e[$];
  int         rdy_mode = 0;
  bit         hold_chk = 0;
  logic [13:0] held;
  int         exp_port [5] = '{0, 1, 2, 3, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Egress sink: picks out_ready, then samples outputs and logs bytes that
  // will transfer on the coming rising edge.
  always @(negedge clk) begin
    int p;
    if (rdy_mode == 0) bus.out_ready = 4'hF;
    else               bus.out_ready = 4'($urandom_range(0, 15));
    if (hold_chk)
      check("stall_hold", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data}, held);
    hold_chk = 0;
    if (bus.out_valid != 4'b0000) begin
      check("onehot", $countones(bus.out_valid), 1);
      p = 0;
      for (int i = 0; i < 4; i++) if (bus.out_valid[i]) p = i;
      if (bus.out_ready[p]) begin
        rx_d.push_back(bus.out_data);
        rx_p.push_back(p);
        rx_s.push_back(bus.out_sop);
        rx_e.push_back(bus.out_eop);
      end else begin
        hold_chk = 1;
        held = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data};
      end
    end else begin
      check("idle_zero", {bus.out_sop, bus.out_eop, bus.out_data}, 0);
    end
  end

  task automatic clear_rx();
    rx_d.delete(); rx_p.delete(); rx_s.delete(); rx_e.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sop = s; bus.in_eop = e;
    while (!bus.in_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++)
      send_byte(pkt[i], i == 0, i == pkt.size() - 1);
  endtask

  task automatic add_parity();
    logic [7:0] x = 8'h00;
    foreach (pkt[i]) x ^= pkt[i];
    pkt.push_back(x);
  endtask

  task automatic expect_pkt(input int port);
    int n = 0;
    while (rx_d.size() < pkt.size() && n < 2000) begin @(negedge clk); n++; end
    check("rx_len", rx_d.size(), pkt.size());
    for (int i = 0; i < pkt.size() && i < rx_d.size(); i++) begin
      check("rx_data", rx_d[i], pkt[i]);
      check("rx_port", rx_p[i], port);
      check("rx_sop", rx_s[i], i == 0);
      check("rx_eop", rx_e[i], i == pkt.size() - 1);
    end
    @(negedge clk);
    clear_rx();
  endtask

  task automatic do_reset();
    bus.rst = 1'b1;
    @(negedge clk);
    bus.rst = 1'b0;
    @(negedge clk);
    clear_rx();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.rst = 1'b1; bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    bus.in_data = 8'h00; bus.out_ready = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_flags", {bus.out_sop, bus.out_eop, bus.out_data}, 0);
    check("rst_ok_cnt", bus.pkt_ok_cnt, 0);
    check("rst_err_cnt", bus.pkt_err_cnt, 0);
    bus.rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.in_ready, 1);

    // Good packet to port 1, with latency check.
    pkt = '{8'h01, 8'hAA, 8'h55, 8'hFE};
    send_pkt();
    check("check_ready_low", bus.in_ready, 0);
    check("check_no_valid", bus.out_valid, 0);
    @(negedge clk);
    check("first_valid", bus.out_valid, 4'b0010);
    check("first_data", {bus.out_sop, bus.out_data}, {1'b1, 8'h01});
    expect_pkt(1);
    check("t1_ready_back", bus.in_ready, 1);
    check("t1_ok", bus.pkt_ok_cnt, 1);
    check("t1_err", bus.pkt_err_cnt, 0);

    // Bad parity.
    pkt = '{8'h01, 8'hAA, 8'h55, 8'h00};
    send_pkt();
    check("t2_ready_low", bus.in_ready, 0);
    @(negedge clk);
    check("t2_ready_back", bus.in_ready, 1);
    check("t2_err", bus.pkt_err_cnt, 1);
    check("t2_ok", bus.pkt_ok_cnt, 1);
    repeat (3) @(negedge clk);
    check("t2_no_output", rx_d.size(), 0);

    // Five packets with random egress stalls, then a maximum-length one.
    do_reset();
    rdy_mode = 1;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: pkt = '{8'h00, 8'h11, 8'h22, 8'h33};
        1: pkt = '{8'hFD, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF9};
        2: pkt = '{8'h02, 8'h02};
        3: pkt = '{8'h07, 8'hC3, 8'h3C, 8'hF8};
        default: pkt = '{8'h41, 8'h99, 8'h66, 8'h00, 8'hFF, 8'h41};
      endcase
      send_pkt();
      expect_pkt(exp_port[k]);
    end
    check("t3_ok", bus.pkt_ok_cnt, 5);
    pkt.delete();
    pkt.push_back(8'hA6);
    for (int i = 1; i < 63; i++) pkt.push_back(8'(i * 7));
    add_parity();
    send_pkt();
    expect_pkt(2);
    check("t3_max_ok", bus.pkt_ok_cnt, 6);
    check("t3_err", bus.pkt_err_cnt, 0);
    rdy_mode = 0;

    // Framing errors.
    do_reset();
    send_byte(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    check("stray_no_err", bus.pkt_err_cnt, 0);
    send_byte(8'h02, 1'b1, 1'b1);
    @(negedge clk);
    check("one_byte_err", bus.pkt_err_cnt, 1);
    check("one_byte_ready", bus.in_ready, 1);
    pkt.delete();
    pkt.push_back(8'h01);
    for (int i = 1; i < 64; i++) pkt.push_back(8'(i + 3));
    add_parity();
    send_pkt();
    @(negedge clk);
    check("long_err", bus.pkt_err_cnt, 2);
    check("long_no_output", rx_d.size(), 0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    pkt = '{8'h03, 8'h10, 8'h13};
    send_pkt();
    expect_pkt(3);
    check("abort_err", bus.pkt_err_cnt, 3);
    check("abort_ok", bus.pkt_ok_cnt, 1);

    // Reset in the middle of SEND.
    do_reset();
    pkt.delete();
    pkt.push_back(8'h02);
    for (int i = 1; i < 9; i++) pkt.push_back(8'(8'h30 + i));
    add_parity();
    send_pkt();
    n = 0;
    while (rx_d.size() < 3 && n < 100) begin @(negedge clk); n++; end
    check("mid_send_reached", rx_d.size() >= 3, 1);
    check("mid_send_ok", bus.pkt_ok_cnt, 1);
    bus.rst = 1'b1;
    @(negedge clk);
    check("rs_valid", bus.out_valid, 0);
    check("rs_flags", {bus.out_sop, bus.out_eop, bus.out_data}, 0);
    check("rs_in_ready", bus.in_ready, 0);
    check("rs_cnts", {bus.pkt_ok_cnt, bus.pkt_err_cnt}, 0);
    bus.rst = 1'b0;
    @(negedge clk);
    clear_rx();
    check("rs_ready_back", bus.in_ready, 1);
    pkt = '{8'h00, 8'h5A, 8'h5A};
    send_pkt();
    expect_pkt(0);
    check("rs_next_ok", bus.pkt_ok_cnt, 1);

    // Counter saturation.
    force dut.ok_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.ok_cnt_q;
    pkt = '{8'h01, 8'hAA, 8'h55, 8'hFE};
    send_pkt();
    expect_pkt(1);
    check("sat_reach", bus.pkt_ok_cnt, 16'hFFFF);
    send_pkt();
    expect_pkt(1);
    check("sat_hold", bus.pkt_ok_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
